// File: rtl/div_unit.sv
// Multi-cycle radix-2 restoring divider for DIV/DIVU in the E stage.
// Divides magnitudes one quotient bit per cycle, then fixes signs when the result is written to HI/LO.
module div_unit #(
  parameter int WIDTH = 32,
  parameter int CNT_W = $clog2(WIDTH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             E_div_start,
  input  logic             E_div_signed,
  input  logic [WIDTH-1:0] E_div_a,
  input  logic [WIDTH-1:0] E_div_b,
  input  logic             E_div_cancel,
  output logic             E_div_stall,
  output logic             E_div_done,
  output logic [WIDTH-1:0] E_div_hi,
  output logic [WIDTH-1:0] E_div_lo
);

  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

  state_t           state, state_nxt;
  logic [CNT_W-1:0] cnt;
  logic [WIDTH-1:0] rem, quo, dvs;
  logic             neg_q, neg_r;
  logic             accept, last_iter, b_zero;
  logic [WIDTH-1:0] a_mag, b_mag, rem_nxt, quo_nxt;
  logic [WIDTH:0]   rem_sh, diff;

  assign accept    = E_div_start & ~E_div_cancel & (state == IDLE);
  assign last_iter = (cnt == CNT_W'(WIDTH - 1));
  assign b_zero    = (E_div_b == '0);
  assign a_mag     = (E_div_signed & E_div_a[WIDTH-1]) ? -E_div_a : E_div_a;
  assign b_mag     = (E_div_signed & E_div_b[WIDTH-1]) ? -E_div_b : E_div_b;

  assign E_div_stall = E_div_start & ~E_div_cancel & (state != DONE);

  // Restoring step: shift next dividend bit into the partial remainder and try to subtract.
  always_comb begin
    rem_sh = {rem, quo[WIDTH-1]};
    diff   = rem_sh - {1'b0, dvs};
    if (!diff[WIDTH]) begin
      rem_nxt = diff[WIDTH-1:0];
      quo_nxt = {quo[WIDTH-2:0], 1'b1};
    end else begin
      rem_nxt = rem_sh[WIDTH-1:0];
      quo_nxt = {quo[WIDTH-2:0], 1'b0};
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (accept) state_nxt = b_zero ? DONE : BUSY;
      BUSY:    if (last_iter) state_nxt = DONE;
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
    if (E_div_cancel) state_nxt = IDLE;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= IDLE;
      cnt        <= '0;
      rem        <= '0;
      quo        <= '0;
      dvs        <= '0;
      neg_q      <= 1'b0;
      neg_r      <= 1'b0;
      E_div_done <= 1'b0;
      E_div_hi   <= '0;
      E_div_lo   <= '0;
    end else begin
      state      <= state_nxt;
      E_div_done <= (state_nxt == DONE);
      case (state)
        IDLE: begin
          if (accept) begin
            cnt   <= '0;
            rem   <= '0;
            quo   <= a_mag;
            dvs   <= b_mag;
            neg_q <= E_div_signed & (E_div_a[WIDTH-1] ^ E_div_b[WIDTH-1]);
            neg_r <= E_div_signed & E_div_a[WIDTH-1];
            if (b_zero) begin
              E_div_hi <= E_div_a;
              E_div_lo <= '1;
            end
          end
        end
        BUSY: begin
          if (E_div_cancel) begin
            cnt <= '0;
          end else begin
            rem <= rem_nxt;
            quo <= quo_nxt;
            cnt <= cnt + 1'b1;
            // Signs are applied only once, as the final result lands in HI/LO.
            if (last_iter) begin
              E_div_hi <= neg_r ? -rem_nxt : rem_nxt;
              E_div_lo <= neg_q ? -quo_nxt : quo_nxt;
            end
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_div_unit.sv
// Directed and random checks of div_unit: stall length, done pulse, HI/LO results,
// cancel/reset mid-operation and back-to-back issue.
module tb_div_unit;

  logic        clk = 1'b0;
  logic        rst;
  logic        div_start, div_signed, div_cancel;
  logic [31:0] div_a, div_b;
  logic        stall, done;
  logic [31:0] hi, lo;

  typedef struct {
    logic [31:0] lo;
    logic [31:0] hi;
  } res_t;

  res_t        scb[$];
  int          checks = 0;
  int          errors = 0;
  logic [31:0] last_lo, last_hi;

  div_unit #(.WIDTH(32)) dut (
    .clk          (clk),
    .rst          (rst),
    .E_div_start  (div_start),
    .E_div_signed (div_signed),
    .E_div_a      (div_a),
    .E_div_b      (div_b),
    .E_div_cancel (div_cancel),
    .E_div_stall  (stall),
    .E_div_done   (done),
    .E_div_hi     (hi),
    .E_div_lo     (lo)
  );

  always #5 clk = ~clk;

  initial begin
    #1000000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1);
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Issues one divide with start held until the DONE cycle, then checks stall length and result.
  task automatic do_div(input logic sgn, input logic [31:0] a, input logic [31:0] b,
                        input logic [31:0] exp_lo, input logic [31:0] exp_hi,
                        input int exp_stall, input string tag);
    res_t exp;
    int   cyc;
    scb.push_back('{exp_lo, exp_hi});
    div_signed = sgn;
    div_a      = a;
    div_b      = b;
    div_start  = 1'b1;
    #1;
    cyc = 0;
    while (stall === 1'b1 && cyc < 100) begin
      cyc++;
      @(posedge clk);
      #2;
    end
    chk({tag, "_stall_cycles"}, cyc, exp_stall);
    chk({tag, "_done"}, {31'd0, done}, 32'd1);
    if (scb.size() == 0) begin
      chk({tag, "_scoreboard_empty"}, 32'd1, 32'd0);
    end else begin
      exp = scb.pop_front();
      chk({tag, "_lo"}, lo, exp.lo);
      chk({tag, "_hi"}, hi, exp.hi);
      last_lo = exp.lo;
      last_hi = exp.hi;
    end
    @(posedge clk);
    #1;
    div_start = 1'b0;
    #1;
    chk({tag, "_done_one_cycle"}, {31'd0, done}, 32'd0);
  endtask

  task automatic watch_no_done(input int n, input string tag);
    logic seen;
    seen = 1'b0;
    repeat (n) begin
      @(posedge clk);
      #1;
      if (done) seen = 1'b1;
    end
    chk(tag, {31'd0, seen}, 32'd0);
  endtask

  initial begin
    logic        [31:0] ua, ub;
    logic signed [31:0] sa, sd;

    rst        = 1'b1;
    div_start  = 1'b0;
    div_signed = 1'b0;
    div_cancel = 1'b0;
    div_a      = '0;
    div_b      = '0;
    last_lo    = '0;
    last_hi    = '0;
    repeat (2) @(posedge clk);
    #1;
    chk("reset_done", {31'd0, done}, 32'd0);
    chk("reset_lo", lo, 32'd0);
    chk("reset_hi", hi, 32'd0);
    chk("reset_stall", {31'd0, stall}, 32'd0);
    rst = 1'b0;
    @(posedge clk);
    #1;

    // start together with cancel is not accepted
    div_start  = 1'b1;
    div_cancel = 1'b1;
    div_a      = 32'd5;
    div_b      = 32'd1;
    #1;
    chk("start_cancel_stall", {31'd0, stall}, 32'd0);
    @(posedge clk);
    #1;
    div_start  = 1'b0;
    div_cancel = 1'b0;
    watch_no_done(40, "start_cancel_no_done");

    do_div(1'b0, 32'd100, 32'd7, 32'd14, 32'd2, 33, "udiv_100_7");
    do_div(1'b1, 32'hFFFFFFF9, 32'd2, 32'hFFFFFFFD, 32'hFFFFFFFF, 33, "sdiv_m7_2");
    do_div(1'b1, 32'd7, 32'hFFFFFFFE, 32'hFFFFFFFD, 32'd1, 33, "sdiv_7_m2");
    do_div(1'b1, 32'h80000000, 32'hFFFFFFFF, 32'h80000000, 32'd0, 33, "sdiv_overflow");
    do_div(1'b0, 32'h80000000, 32'hFFFFFFFF, 32'd0, 32'h80000000, 33, "udiv_big");
    do_div(1'b0, 32'h1234, 32'd0, 32'hFFFFFFFF, 32'h1234, 1, "udiv_zero");
    do_div(1'b1, 32'hFFFFFF00, 32'd0, 32'hFFFFFFFF, 32'hFFFFFF00, 1, "sdiv_zero");

    // back-to-back: second divide issued the cycle after the first one's DONE
    do_div(1'b0, 32'd100, 32'd7, 32'd14, 32'd2, 33, "b2b_first");
    do_div(1'b0, 32'd9, 32'd3, 32'd3, 32'd0, 33, "b2b_second");

    for (int i = 0; i < 4; i++) begin
      ua = $urandom;
      ub = $urandom_range(1, 65535);
      do_div(1'b0, ua, ub, ua / ub, ua % ub, 33, "rand_udiv");
    end
    for (int i = 0; i < 4; i++) begin
      sa = $urandom;
      sd = $urandom_range(2, 1000);
      if (i[0]) sd = -sd;
      do_div(1'b1, sa, sd, sa / sd, sa % sd, 33, "rand_sdiv");
    end

    // cancel at BUSY cycle 10
    div_signed = 1'b0;
    div_a      = 32'd1000;
    div_b      = 32'd3;
    div_start  = 1'b1;
    repeat (11) @(posedge clk);
    #1;
    div_cancel = 1'b1;
    #1;
    chk("cancel_stall_drop", {31'd0, stall}, 32'd0);
    @(posedge clk);
    #1;
    div_cancel = 1'b0;
    div_start  = 1'b0;
    watch_no_done(40, "cancel_no_done");
    chk("cancel_lo_hold", lo, last_lo);
    chk("cancel_hi_hold", hi, last_hi);
    do_div(1'b0, 32'd1000, 32'd3, 32'd333, 32'd1, 33, "after_cancel");

    // reset at BUSY cycle 10
    do_div(1'b0, 32'd100, 32'd7, 32'd14, 32'd2, 33, "pre_reset");
    div_a     = 32'd500;
    div_b     = 32'd9;
    div_start = 1'b1;
    repeat (11) @(posedge clk);
    #3;
    rst       = 1'b1;
    div_start = 1'b0;
    #1;
    chk("midrst_lo", lo, 32'd0);
    chk("midrst_hi", hi, 32'd0);
    chk("midrst_done", {31'd0, done}, 32'd0);
    chk("midrst_stall", {31'd0, stall}, 32'd0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    watch_no_done(40, "midrst_no_done");
    do_div(1'b0, 32'd500, 32'd9, 32'd55, 32'd5, 33, "after_reset");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/div_unit.md
Name: div_unit

Overview:
- Multi-cycle radix-2 restoring integer divider in the master Execute stage of the dual-issue MIPS pipeline.
- Executes DIV/DIVU and writes the HI/LO results.
- Drives E_div_stall, which the hazard unit uses to freeze F/D/E/M while a division is in flight.
- Accepts a cancel so that branch or exception flushes can abort an in-flight division.

Parameters:
- WIDTH, 32, operand/result width in bits (power of 2, >=4).
- CNT_W, $clog2(WIDTH), iteration counter width.

Ports:
- clk  input  1  pipeline clock.
- rst  input  1  asynchronous, active-high reset.
- E_div_start  input  1  master E-stage instruction is DIV/DIVU and valid.
- E_div_signed  input  1  1=DIV (signed), 0=DIVU; sampled on accept.
- E_div_a  input  WIDTH  dividend (rs); sampled on accept.
- E_div_b  input  WIDTH  divisor (rt); sampled on accept.
- E_div_cancel  input  1  abort the current operation (flush of E stage).
- E_div_stall  output  1  combinational; high while a started division has not completed.
- E_div_done  output  1  registered; high for exactly one cycle when the result is valid.
- E_div_hi  output  WIDTH  remainder.
- E_div_lo  output  WIDTH  quotient.

Behaviour:
- Clock and reset: one clock, clk. Reset rst is asynchronous and active-high.
- Reset values: state=IDLE, counter=0, E_div_done=0, E_div_hi=0, E_div_lo=0. E_div_stall=0 follows because it is combinational.
- States:
  - IDLE -> BUSY when E_div_start & ~E_div_cancel & divisor!=0. Operands are latched on this transition.
  - IDLE -> DONE when E_div_start & ~E_div_cancel & divisor==0 (divide-by-zero fast path).
  - BUSY: one quotient bit per cycle. After WIDTH iterations (counter WIDTH-1 -> wrap) go to DONE.
  - DONE -> IDLE unconditionally after one cycle.
  - Any state -> IDLE on E_div_cancel, on the next edge. Latched operands are discarded and hi/lo are not updated.
- E_div_stall = E_div_start & ~E_div_cancel & (state != DONE). It is asserted in the accept cycle itself, so E never advances past an unstarted divide.
- Latency:
  - Normal divide: accept cycle + WIDTH BUSY cycles, so E_div_stall is high for WIDTH+1 = 33 cycles.
  - DONE cycle: stall=0, done=1, and the pipeline advances.
  - Divide-by-zero: stall is high for 1 cycle, then DONE.
- No double start: in DONE the same instruction is still in E but stall is 0, so E advances. A new divide seen in the following IDLE cycle is a distinct instruction and is accepted.
- Signed arithmetic:
  - The magnitudes |a| and |b| are divided unsigned.
  - Quotient is negated if sign(a) != sign(b).
  - Remainder takes the sign of a.
  - Invariant: a = q*b + r, with |r| < |b|.
- Overflow case: signed 0x80000000 / 0xFFFFFFFF gives lo=0x80000000, hi=0. This falls out of the magnitude path with no special case.
- Divide-by-zero: lo = all ones (0xFFFFFFFF), hi = a, for both signed and unsigned.
- Output holding: E_div_hi/E_div_lo update only on entry to DONE. They hold until the next completed division or reset.
- Simultaneous events:
  - Cancel together with start in IDLE: no accept, stall=0.
  - Cancel in DONE: done still pulses and the result is still written (completion has priority). The next state is IDLE either way.
- Reset mid-operation clears everything immediately. No result is produced.

Test Plan:
- Unsigned divide, hold start: a=100, b=7 -> stall high exactly 33 cycles; then done=1 for 1 cycle with lo=14, hi=2.
- Signed divide: a=-7 (0xFFFFFFF9), b=2 -> lo=0xFFFFFFFD (-3), hi=0xFFFFFFFF (-1). Also a=7, b=-2 -> lo=-3, hi=1.
- Signed overflow: a=0x80000000, b=0xFFFFFFFF -> lo=0x80000000, hi=0. Same operands with DIVU -> lo=0, hi=0x80000000.
- Divide-by-zero: a=0x1234, b=0 -> stall for 1 cycle; done next cycle with lo=0xFFFFFFFF, hi=0x1234.
- Cancel and reset mid-operation:
  - Assert E_div_cancel at BUSY cycle 10 -> stall drops the same cycle, state=IDLE next edge, done never pulses, hi/lo keep their previous values.
  - Repeat with rst instead of cancel -> all outputs read 0 asynchronously.
- Back-to-back: divide 100/7, then on the cycle after DONE start 9/3 -> second divide is accepted once (33 stall cycles) with lo=3, hi=0. No spurious restart occurs in the first divide's DONE cycle.
